// File: rtl/sdp_bram_responder_pkg.sv
// Shared types and elaboration helpers for the simple-dual-port BRAM responder.
package bram_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } bram_state_e;

    localparam int READ_LATENCY_MIN = 32'sd1;
    localparam int READ_LATENCY_MAX = 32'sd2;

    // Ceiling log2, never less than one bit so a one-word memory still has an address.
    function automatic int clogb2(input int value);
        int r;
        r = 32'sd1;
        for (int i = 32'sd1; i < 32'sd31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 32'sd1;
            end
        end
        return r;
    endfunction

    function automatic bit read_latency_ok(input int lat);
        return (lat >= READ_LATENCY_MIN) && (lat <= READ_LATENCY_MAX);
    endfunction

endpackage

// File: rtl/sdp_bram_responder_if.sv
// Port-A write / port-B read bus between a BRAM controller and the responder.
interface sdp_bram_responder_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 24
);
    logic [ADDR_WIDTH-1:0] bram_addra;
    logic [DATA_WIDTH-1:0] bram_dina;
    logic                  bram_wea;
    logic                  bram_ena;
    logic                  bram_rsta;
    logic [ADDR_WIDTH-1:0] bram_addrb;
    logic                  bram_enb;
    logic                  bram_rstb;
    logic [DATA_WIDTH-1:0] bram_doutb;
    logic                  bram_rst_busy;

    modport master (
        output bram_addra, bram_dina, bram_wea, bram_ena, bram_rsta,
        output bram_addrb, bram_enb, bram_rstb,
        input  bram_doutb, bram_rst_busy
    );

    modport slave (
        input  bram_addra, bram_dina, bram_wea, bram_ena, bram_rsta,
        input  bram_addrb, bram_enb, bram_rstb,
        output bram_doutb, bram_rst_busy
    );
endinterface

// File: rtl/sdp_bram_responder_clear_seq.sv
// Clear-sweep sequencer: walks every address once after reset or a clear request,
// holding busy until the last word has been zeroed.
module bram_clear_seq
    import bram_pkg::*;
#(
    parameter int DEPTH      = 31,
    parameter int ADDR_WIDTH = clogb2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr_req,
    output logic                  clear_we,
    output logic [ADDR_WIDTH-1:0] clear_addr,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 32'sd1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    bram_state_e           state_r, state_s;
    logic [ADDR_WIDTH-1:0] clr_addr_r, clr_addr_s;
    logic                  busy_r, busy_s;

    // State, sweep pointer and busy flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= CLEAR;
            clr_addr_r <= ADDR_ZERO;
            busy_r     <= 1'b1;
        end else begin
            state_r    <= state_s;
            clr_addr_r <= clr_addr_s;
            busy_r     <= busy_s;
        end
    end

    // Next-state logic; a request seen mid-sweep rewinds the pointer to zero.
    always_comb begin
        state_s    = state_r;
        clr_addr_s = clr_addr_r;
        busy_s     = busy_r;
        case (state_r)
            IDLE: begin
                if (clr_req) begin
                    state_s    = CLEAR;
                    clr_addr_s = ADDR_ZERO;
                    busy_s     = 1'b1;
                end else begin
                    busy_s     = 1'b0;
                end
            end
            CLEAR: begin
                if (clr_req) begin
                    clr_addr_s = ADDR_ZERO;
                    busy_s     = 1'b1;
                end else if (clr_addr_r == LAST_ADDR) begin
                    state_s    = IDLE;
                    clr_addr_s = ADDR_ZERO;
                    busy_s     = 1'b0;
                end else begin
                    clr_addr_s = clr_addr_r + ADDR_ONE;
                    busy_s     = 1'b1;
                end
            end
            default: begin
                state_s    = CLEAR;
                clr_addr_s = ADDR_ZERO;
                busy_s     = 1'b1;
            end
        endcase
    end

    assign clear_we   = (state_r == CLEAR);
    assign clear_addr = clr_addr_r;
    assign busy       = busy_r;

endmodule

// File: rtl/sdp_bram_responder.sv
// Simple-dual-port BRAM model with vendor-style clear sweep, read-first collisions
// and a one- or two-stage read pipeline.
module sdp_bram_responder
    import bram_pkg::*;
#(
    parameter int DEPTH        = 31,
    parameter int DATA_WIDTH   = 24,
    parameter int READ_LATENCY = 1,
    parameter int ADDR_WIDTH   = clogb2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sdp_bram_responder_if.slave  bram
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
        $error("sdp_bram_responder: READ_LATENCY must be 1 or 2");
    end

    logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];
    logic                  clr_req_s;
    logic                  clear_we_s;
    logic [ADDR_WIDTH-1:0] clear_addr_s;
    logic                  busy_s;
    logic                  wr_en_s;
    logic                  addrb_ok_s;
    logic [DATA_WIDTH-1:0] rd_data_s;
    logic [DATA_WIDTH-1:0] dout_r;
    logic [DATA_WIDTH-1:0] s1_data_r;
    logic                  s1_valid_r;

    assign clr_req_s = bram.bram_rsta | bram.bram_rstb;

    bram_clear_seq #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_seq (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr_req    (clr_req_s),
        .clear_we   (clear_we_s),
        .clear_addr (clear_addr_s),
        .busy       (busy_s)
    );

    assign wr_en_s    = bram.bram_ena & bram.bram_wea & ~busy_s & ~clr_req_s
                      & ({1'b0, bram.bram_addra} < DEPTH_W);
    assign addrb_ok_s = ({1'b0, bram.bram_addrb} < DEPTH_W);

    // Memory array; the sweep and user writes are mutually exclusive by construction.
    always_ff @(posedge clk) begin
        if (clear_we_s) begin
            mem_r[clear_addr_s] <= DATA_ZERO;
        end else if (wr_en_s) begin
            mem_r[bram.bram_addra] <= bram.bram_dina;
        end
    end

    // Array read; the old word is seen on a same-address write edge (read-first).
    always_comb begin
        rd_data_s = DATA_ZERO;
        if (!busy_s && addrb_ok_s) begin
            rd_data_s = mem_r[bram.bram_addrb];
        end else begin
            rd_data_s = DATA_ZERO;
        end
    end

    // Read pipeline; rstb flushes both the output and the in-flight stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_r     <= DATA_ZERO;
            s1_data_r  <= DATA_ZERO;
            s1_valid_r <= 1'b0;
        end else if (bram.bram_rstb) begin
            dout_r     <= DATA_ZERO;
            s1_valid_r <= 1'b0;
        end else if (READ_LATENCY == 32'sd2) begin
            if (bram.bram_enb) begin
                s1_data_r <= rd_data_s;
            end
            s1_valid_r <= bram.bram_enb;
            if (s1_valid_r) begin
                dout_r <= s1_data_r;
            end
        end else begin
            if (bram.bram_enb) begin
                dout_r <= rd_data_s;
            end
        end
    end

    assign bram.bram_doutb    = dout_r;
    assign bram.bram_rst_busy = busy_s;

endmodule

// File: tb/tb_sdp_bram_responder.sv
// Bench for sdp_bram_responder: latency-1 and latency-2 instances share one stimulus
// stream and are compared every cycle against a word-level model.
module tb_sdp_bram_responder;

    localparam int DEPTH = 31;
    localparam int AW    = 5;
    localparam int DW    = 24;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] addra = '0;
    logic [DW-1:0] dina  = '0;
    logic          wea   = 1'b0;
    logic          ena   = 1'b0;
    logic          rsta  = 1'b0;
    logic [AW-1:0] addrb = '0;
    logic          enb   = 1'b0;
    logic          rstb  = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sdp_bram_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();
    sdp_bram_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if2 ();

    assign if1.bram_addra = addra;  assign if2.bram_addra = addra;
    assign if1.bram_dina  = dina;   assign if2.bram_dina  = dina;
    assign if1.bram_wea   = wea;    assign if2.bram_wea   = wea;
    assign if1.bram_ena   = ena;    assign if2.bram_ena   = ena;
    assign if1.bram_rsta  = rsta;   assign if2.bram_rsta  = rsta;
    assign if1.bram_addrb = addrb;  assign if2.bram_addrb = addrb;
    assign if1.bram_enb   = enb;    assign if2.bram_enb   = enb;
    assign if1.bram_rstb  = rstb;   assign if2.bram_rstb  = rstb;

    sdp_bram_responder #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .bram(if1));
    sdp_bram_responder #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .READ_LATENCY(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .bram(if2));

    // Word-level model: a clear request blanks the whole array at once and keeps the
    // part busy for DEPTH edges after the most recent request.
    logic [DW-1:0] m_mem [0:DEPTH-1];
    int            m_busy_cnt;
    logic [DW-1:0] m_d1, m_d2, m_pd, m_rd;
    bit            m_pv, m_busy_before;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_busy_cnt = DEPTH;
        m_d1 = '0; m_d2 = '0; m_pd = '0; m_pv = 1'b0;
    endtask

    task automatic model_step();
        m_busy_before = (m_busy_cnt > 0);
        m_rd = '0;
        if (!m_busy_before && int'(addrb) < DEPTH) m_rd = m_mem[addrb];
        if (ena && wea && !m_busy_before && !(rsta || rstb) && int'(addra) < DEPTH)
            m_mem[addra] = dina;
        if (rsta || rstb) begin
            m_busy_cnt = DEPTH;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end else if (m_busy_cnt > 0) begin
            m_busy_cnt = m_busy_cnt - 1;
        end
        if (rstb) m_d1 = '0;
        else if (enb) m_d1 = m_rd;
        if (rstb) begin
            m_d2 = '0;
            m_pv = 1'b0;
        end else begin
            if (m_pv) m_d2 = m_pd;
            m_pv = enb;
            if (enb) m_pd = m_rd;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle compare of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("dout_lat1", 32'(if1.bram_doutb), 32'(m_d1));
            check("dout_lat2", 32'(if2.bram_doutb), 32'(m_d2));
            check("busy_lat1", 32'(if1.bram_rst_busy), 32'(m_busy_cnt > 0));
            check("busy_lat2", 32'(if2.bram_rst_busy), 32'(m_busy_cnt > 0));
        end
    end

    task automatic wr(input int a, input logic [DW-1:0] d);
        ena = 1'b1; wea = 1'b1; addra = AW'(a); dina = d;
        @(negedge clk);
        ena = 1'b0; wea = 1'b0;
    endtask

    task automatic rd(input int a);
        addrb = AW'(a); enb = 1'b1;
        @(negedge clk);
        enb = 1'b0;
    endtask

    // Counts negedge samples with busy high, starting with the current one.
    task automatic wait_idle(output int n);
        n = 0;
        while (if1.bram_rst_busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
            ena = 1'b0; wea = 1'b0;
        end
        if (n >= 200) check("busy_timeout", 32'(n), 32'd0);
    endtask

    int n;

    initial begin
        repeat (5) @(negedge clk);
        check("reset_busy", 32'(if1.bram_rst_busy), 32'd1);
        check("reset_dout", 32'(if1.bram_doutb), 32'd0);
        reset_n = 1'b1;
        wait_idle(n);
        check("powerup_busy_len", 32'(n), 32'd31);
        for (int i = 0; i < DEPTH; i++) begin
            rd(i);
            check("powerup_read", 32'(if1.bram_doutb), 32'd0);
        end

        // Basic write then read, then hold with enb low.
        wr(7, 24'hA5A5A5);
        rd(7);
        check("wr_rd_lat1", 32'(if1.bram_doutb), 32'h00A5A5A5);
        check("model_wr_rd", 32'(m_d1), 32'h00A5A5A5);
        check("wr_rd_lat2_early", 32'(if2.bram_doutb), 32'd0);
        @(negedge clk);
        check("wr_rd_lat2", 32'(if2.bram_doutb), 32'h00A5A5A5);
        repeat (9) @(negedge clk);
        check("hold_lat1", 32'(if1.bram_doutb), 32'h00A5A5A5);

        // Same-address collision returns the old word.
        wr(3, 24'h000011);
        ena = 1'b1; wea = 1'b1; addra = 5'd3; dina = 24'h000022; addrb = 5'd3; enb = 1'b1;
        @(negedge clk);
        ena = 1'b0; wea = 1'b0; enb = 1'b0;
        check("collision_old", 32'(if1.bram_doutb), 32'h00000011);
        rd(3);
        check("collision_new", 32'(if1.bram_doutb), 32'h00000022);

        // Clear mid-use with a write attempted while busy.
        for (int i = 0; i < DEPTH; i++) wr(i, DW'(i + 1));
        rd(4);
        check("fill_read", 32'(if1.bram_doutb), 32'd5);
        rsta = 1'b1;
        @(negedge clk);
        rsta = 1'b0;
        check("rsta_keeps_dout", 32'(if1.bram_doutb), 32'd5);
        ena = 1'b1; wea = 1'b1; addra = 5'd5; dina = 24'hFFFFFF;
        wait_idle(n);
        check("rsta_busy_len", 32'(n), 32'd31);
        for (int i = 0; i < DEPTH; i++) begin
            rd(i);
            check("cleared_read", 32'(if1.bram_doutb), 32'd0);
        end

        // rstb part-way through a sweep restarts it and zeroes the outputs.
        wr(2, 24'h777777);
        rd(2);
        @(negedge clk);
        check("pre_rstb_lat2", 32'(if2.bram_doutb), 32'h00777777);
        rsta = 1'b1;
        @(negedge clk);
        rsta = 1'b0;
        repeat (9) @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        rstb = 1'b0;
        check("rstb_dout_lat1", 32'(if1.bram_doutb), 32'd0);
        check("rstb_dout_lat2", 32'(if2.bram_doutb), 32'd0);
        wait_idle(n);
        check("restart_busy_len", 32'(10 + n), 32'd41);

        // Two-stage latency and out-of-range read.
        wr(30, 24'h123456);
        rd(30);
        check("lat1_addr30", 32'(if1.bram_doutb), 32'h00123456);
        check("lat2_addr30_early", 32'(if2.bram_doutb), 32'd0);
        @(negedge clk);
        check("lat2_addr30", 32'(if2.bram_doutb), 32'h00123456);
        check("model_lat2", 32'(m_d2), 32'h00123456);
        rd(31);
        check("oor_lat1", 32'(if1.bram_doutb), 32'd0);
        @(negedge clk);
        check("oor_lat2", 32'(if2.bram_doutb), 32'd0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
